// File: rtl/fb_pkg.sv
// Shared widths, grant-state encoding and RGB565 field layout for the framebuffer arbiter.
package fb_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 16;

    typedef logic [1:0] grant_t;
    localparam logic [1:0] GNT_IDLE = 2'd0;
    localparam logic [1:0] GNT_DISP = 2'd1;
    localparam logic [1:0] GNT_HOST = 2'd2;

    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

endpackage

// File: rtl/fb_wr_hold.sv
// One-entry write holding register; ready is registered so it never depends on wr_valid.
module fb_wr_hold
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              commit_i,
    output logic              wr_ready_o,
    output logic              hold_valid_o,
    output logic [ADDR_W-1:0] hold_addr_o,
    output logic [DATA_W-1:0] hold_data_o
);

    logic              hold_valid_q;
    logic              hold_valid_d;
    logic              wr_ready_q;
    logic              accept;
    logic [ADDR_W-1:0] hold_addr_q;
    logic [DATA_W-1:0] hold_data_q;

    assign accept = wr_valid_i & wr_ready_q;

    // Accept and commit are exclusive: ready is only high while the entry is empty.
    always_comb begin
        hold_valid_d = hold_valid_q;
        if (accept) begin
            hold_valid_d = 1'b1;
        end else if (commit_i) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            wr_ready_q   <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            wr_ready_q   <= !hold_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            hold_addr_q <= wr_addr_i;
            hold_data_q <= wr_data_i;
        end
    end

    assign wr_ready_o   = wr_ready_q;
    assign hold_valid_o = hold_valid_q;
    assign hold_addr_o  = hold_addr_q;
    assign hold_data_o  = hold_data_q;

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: display reads win over host writes, with read-after-pending-write forwarding.
module fb_arbiter
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  wr_commit_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic              hold_valid;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic              commit;
    grant_t            grant_d;
    grant_t            grant_q;
    logic              rd_vld_p1;
    logic              fwd_hit_p1_q;
    logic [DATA_W-1:0] fwd_data_p1_q;
    logic              disp_valid_q;
    logic [DATA_W-1:0] disp_data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    fb_wr_hold u_wr_hold (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid_i   (wr_valid),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .commit_i     (commit),
        .wr_ready_o   (wr_ready),
        .hold_valid_o (hold_valid),
        .hold_addr_o  (hold_addr),
        .hold_data_o  (hold_data)
    );

    always_comb begin
        grant_d = GNT_IDLE;
        if (disp_req) begin
            grant_d = GNT_DISP;
        end else if (hold_valid) begin
            grant_d = GNT_HOST;
        end
    end

    assign commit = (grant_d == GNT_HOST);

    // RAM command is gated by rst_n so nothing reaches the RAM while reset is held.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = disp_addr;
        mem_wdata = '0;
        if (rst_n) begin
            if (grant_d == GNT_DISP) begin
                mem_en = 1'b1;
            end else if (grant_d == GNT_HOST) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = hold_addr;
                mem_wdata = hold_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= GNT_IDLE;
        end else begin
            grant_q <= grant_d;
        end
    end

    // Stage p1: RAM read in progress; a registered DISP grant marks it valid.
    assign rd_vld_p1 = (grant_q == GNT_DISP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_hit_p1_q <= 1'b0;
        end else begin
            fwd_hit_p1_q <= disp_req & hold_valid & (disp_addr == hold_addr);
        end
    end

    always_ff @(posedge clk) begin
        fwd_data_p1_q <= hold_data;
    end

    // Stage p2: return pixel, preferring the pending write over stale RAM data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            disp_valid_q <= rd_vld_p1;
            if (rd_vld_p1) begin
                disp_data_q <= fwd_hit_p1_q ? fwd_data_p1_q : mem_rdata;
            end
        end
    end

    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;

    always_comb begin
        cnt_d = cnt_q;
        if (frame_start) begin
            cnt_d = commit ? CNT_W'(1) : '0;
        end else if (commit) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wr_commit_cnt = cnt_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: vector table plus directed sequences, display reads checked through a scoreboard.
module tb_fb_arbiter;
    import fb_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              frame_start;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [CNT_W-1:0]  wr_commit_cnt;

    fb_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .disp_req      (disp_req),
        .disp_addr     (disp_addr),
        .disp_valid    (disp_valid),
        .disp_data     (disp_data),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .wr_commit_cnt (wr_commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with one-cycle read latency.
    logic [DATA_W-1:0] ram [0:32767] = '{default: 16'h0000};
    int we_cnt = 0;
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_cnt        <= we_cnt + 1;
        end else if (mem_en) begin
            mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        logic              dreq;
        logic [ADDR_W-1:0] daddr;
        logic              wv;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic              fs;
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] maddr;
        logic [DATA_W-1:0] mwdata;
    } vec_t;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } sb_t;

    vec_t              vecs [10];
    sb_t               sb_q [$];
    logic [DATA_W-1:0] ref_mem [0:32767] = '{default: 16'h0000};
    logic              m_hv = 1'b0;
    logic              m_rdy = 1'b0;
    logic [ADDR_W-1:0] m_ha = '0;
    logic [DATA_W-1:0] m_hd = '0;
    logic [CNT_W-1:0]  m_cnt = '0;
    int                cyc = 0;
    int                n_chk = 0;
    int                n_fail = 0;
    int                we_before = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, required %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic dr, input logic [ADDR_W-1:0] da, input logic wv,
                         input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd, input logic fs);
        disp_req    = dr;
        disp_addr   = da;
        wr_valid    = wv;
        wr_addr     = wa;
        wr_data     = wd;
        frame_start = fs;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    // Advance one clock: update the reference model from the current inputs, then check outputs.
    task automatic step();
        logic              commit;
        logic              acc;
        logic [DATA_W-1:0] exp_d;
        commit = m_hv && !disp_req;
        acc    = wr_valid && m_rdy;
        if (disp_req) begin
            exp_d = (m_hv && m_ha == disp_addr) ? m_hd : ref_mem[disp_addr];
            sb_q.push_back('{due: cyc + 2, data: exp_d});
        end
        if (commit) ref_mem[m_ha] = m_hd;
        if (frame_start) m_cnt = commit ? 16'h0001 : 16'h0000;
        else if (commit && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
        if (acc) begin
            m_hv = 1'b1;
            m_ha = wr_addr;
            m_hd = wr_data;
        end else if (commit) begin
            m_hv = 1'b0;
        end
        m_rdy = !m_hv;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            chk("disp_valid", 32'(disp_valid), 32'h1);
            chk("disp_data", 32'(disp_data), 32'(sb_q[0].data));
            void'(sb_q.pop_front());
        end else begin
            chk("disp_valid_idle", 32'(disp_valid), 32'h0);
        end
        chk("wr_ready", 32'(wr_ready), 32'(m_rdy));
        chk("wr_commit_cnt", 32'(wr_commit_cnt), 32'(m_cnt));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //           dreq  daddr     wv    waddr     wdata     fs    en    we    maddr     mwdata
        vecs[0] = '{1'b0, 15'h0000, 1'b1, 15'h0010, 16'hF800, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000};
        vecs[1] = '{1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 15'h0010, 16'hF800};
        vecs[2] = '{1'b1, 15'h0010, 1'b0, 15'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 15'h0010, 16'h0000};
        vecs[3] = '{1'b1, 15'h0020, 1'b1, 15'h0020, 16'h1234, 1'b0, 1'b1, 1'b0, 15'h0020, 16'h0000};
        vecs[4] = '{1'b1, 15'h0020, 1'b0, 15'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 15'h0020, 16'h0000};
        vecs[5] = '{1'b1, 15'h0030, 1'b0, 15'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 15'h0030, 16'h0000};
        vecs[6] = '{1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 15'h0020, 16'h1234};
        vecs[7] = '{1'b0, 15'h0000, 1'b1, 15'h0040, 16'h001F, 1'b1, 1'b0, 1'b0, 15'h0000, 16'h0000};
        vecs[8] = '{1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 15'h0040, 16'h001F};
        vecs[9] = '{1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000};

        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        drive(1'b1, 15'h0010, 1'b1, 15'h0010, 16'h0001, 1'b0);
        #1;
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_wr_ready", 32'(wr_ready), 32'h0);
        chk("rst_disp_valid", 32'(disp_valid), 32'h0);
        chk("rst_disp_data", 32'(disp_data), 32'h0);
        chk("rst_cnt", 32'(wr_commit_cnt), 32'h0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        chk("ready_before_first_edge", 32'(wr_ready), 32'h0);
        step();

        foreach (vecs[i]) begin
            drive(vecs[i].dreq, vecs[i].daddr, vecs[i].wv, vecs[i].waddr, vecs[i].wdata, vecs[i].fs);
            #1;
            chk($sformatf("vec%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].en));
            chk($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].we));
            if (vecs[i].en) chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].maddr));
            chk($sformatf("vec%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].mwdata));
            step();
        end
        chk("ram_0010", 32'(ram[15'h0010]), 32'h0000F800);
        chk("ram_0020", 32'(ram[15'h0020]), 32'h00001234);

        // Display holds the RAM for 200 cycles while a write waits.
        drive(1'b1, 15'h0000, 1'b1, 15'h0100, 16'hABCD, 1'b0);
        for (int i = 0; i < 200; i++) begin
            disp_addr = 15'(i);
            #1;
            chk("stall_no_we", 32'(mem_we), 32'h0);
            step();
        end
        idle();
        #1;
        chk("stall_commit_we", 32'(mem_we), 32'h1);
        chk("stall_commit_addr", 32'(mem_addr), 32'h0100);
        chk("stall_commit_wdata", 32'(mem_wdata), 32'hABCD);
        step();
        step();
        step();

        // Read of an address with a pending write returns the held data.
        drive(1'b1, 15'h0001, 1'b1, 15'h1234, 16'h07E0, 1'b0);
        #1;
        step();
        drive(1'b1, 15'h1234, 1'b0, '0, '0, 1'b0);
        #1;
        chk("fwd_no_we", 32'(mem_we), 32'h0);
        step();
        step();
        idle();
        #1;
        chk("fwd_commit_addr", 32'(mem_addr), 32'h1234);
        step();
        step();
        step();
        chk("ram_1234", 32'(ram[15'h1234]), 32'h07E0);
        drive(1'b1, 15'h1234, 1'b0, '0, '0, 1'b0);
        step();
        idle();
        step();
        step();

        // Counter saturation from a preloaded near-full value.
        force dut.cnt_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.cnt_q;
        cyc++;
        m_cnt = 16'hFFFE;
        #1;
        chk("cnt_preload", 32'(wr_commit_cnt), 32'hFFFE);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, 1'b1, 15'(512 + k), 16'(k + 1), 1'b0);
            step();
            idle();
            step();
        end
        chk("cnt_saturated", 32'(wr_commit_cnt), 32'hFFFF);

        // Reset with a held write and a display read in flight.
        drive(1'b1, 15'h0002, 1'b1, 15'h0055, 16'hBEEF, 1'b0);
        step();
        drive(1'b1, 15'h0003, 1'b0, '0, '0, 1'b0);
        step();
        we_before = we_cnt;
        drive(1'b1, 15'h0004, 1'b1, 15'h0066, 16'h1111, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_en", 32'(mem_en), 32'h0);
        chk("midrst_mem_we", 32'(mem_we), 32'h0);
        chk("midrst_wr_ready", 32'(wr_ready), 32'h0);
        chk("midrst_disp_valid", 32'(disp_valid), 32'h0);
        chk("midrst_cnt", 32'(wr_commit_cnt), 32'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("midrst_hold_mem_en", 32'(mem_en), 32'h0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        m_hv  = 1'b0;
        m_rdy = 1'b0;
        m_cnt = '0;
        sb_q.delete();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("postrst_no_we", 32'(mem_we), 32'h0);
            step();
        end
        chk("postrst_we_count", 32'(we_cnt), 32'(we_before));
        chk("postrst_ram_0055", 32'(ram[15'h0055]), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
